// File: rtl/board_pkg.sv
// Shared board geometry and tile-code definitions for the board RAM,
// the initialisation sequencer and the renderer.
package board_pkg;

    localparam int COLS   = 32;
    localparam int ROWS   = 32;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 4;

    typedef enum logic [DATA_W-1:0] {
        TILE_EMPTY        = DATA_W'(0),
        TILE_WALL         = DATA_W'(1),
        TILE_PELLET       = DATA_W'(2),
        TILE_POWER        = DATA_W'(3),
        TILE_GATE         = DATA_W'(4),
        TILE_PACMAN_SPAWN = DATA_W'(5),
        TILE_GHOST_SPAWN  = DATA_W'(6)
    } tile_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_DONE = 1'b1
    } seq_state_t;

endpackage

// File: rtl/board_layout_rom.sv
// Combinational tile-address to initial-tile-code map for the playfield:
// outer walls, ghost box with gate and spawn row, power pellets, pillars.
module board_layout_rom #(
    parameter int COLS   = 32,
    parameter int ROWS   = 32,
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [3:0]        tile
);
    import board_pkg::*;

    localparam int CR    = ROWS / 2;
    localparam int CC    = COLS / 2;
    localparam int CELLS = COLS * ROWS;

    logic [ADDR_W-1:0] row_s;
    logic [ADDR_W-1:0] col_s;
    int                row_i_s;
    int                col_i_s;
    int                addr_i_s;
    tile_t             tile_s;

    // Power-of-two widths reduce the row/column split to a shift and a mask.
    generate
        if ((COLS & (COLS - 1)) == 0) begin : g_pow2
            assign row_s = addr >> $clog2(COLS);
            assign col_s = addr & ADDR_W'(COLS - 1);
        end else begin : g_div
            assign row_s = addr / ADDR_W'(COLS);
            assign col_s = addr % ADDR_W'(COLS);
        end
    endgenerate

    assign row_i_s  = int'(row_s);
    assign col_i_s  = int'(col_s);
    assign addr_i_s = int'(addr);

    // Priority-ordered layout rules; the first matching rule wins.
    always_comb begin
        tile_s = TILE_PELLET;
        if (addr_i_s >= CELLS) begin
            tile_s = TILE_EMPTY;
        end else if (row_i_s == 0 || row_i_s == ROWS - 1 ||
                     col_i_s == 0 || col_i_s == COLS - 1) begin
            tile_s = TILE_WALL;
        end else if (row_i_s == CR - 2 && col_i_s >= CC - 1 && col_i_s <= CC) begin
            tile_s = TILE_GATE;
        end else if (row_i_s == CR - 1 && col_i_s >= CC - 2 && col_i_s <= CC + 1) begin
            tile_s = TILE_GHOST_SPAWN;
        end else if (row_i_s >= CR - 2 && row_i_s <= CR &&
                     col_i_s >= CC - 3 && col_i_s <= CC + 2) begin
            tile_s = TILE_WALL;
        end else if (row_i_s == ROWS - 3 && col_i_s == CC) begin
            tile_s = TILE_PACMAN_SPAWN;
        end else if ((row_i_s == 1 || row_i_s == ROWS - 2) &&
                     (col_i_s == 1 || col_i_s == COLS - 2)) begin
            tile_s = TILE_POWER;
        end else if (row_s[0] == 1'b0 && col_s[0] == 1'b0) begin
            tile_s = TILE_WALL;
        end else begin
            tile_s = TILE_PELLET;
        end
    end

    assign tile = 4'(tile_s);

endmodule

// File: rtl/reset_board_seq.sv
// Board-initialisation sequencer: after reset sweeps every tile address once,
// raising hold (board RAM write enable). Optional replay: RESET_BOARD_REPLAY_EN.
module reset_board_seq #(
    parameter int COLS   = 32,
    parameter int ROWS   = 32,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef RESET_BOARD_REPLAY_EN
    input  logic              restart,
`endif
    output logic              hold,
    output logic [ADDR_W-1:0] overwrite_addr,
    output logic [DATA_W-1:0] initial_data
);
    import board_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

    seq_state_t        state_r;
    seq_state_t        state_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_next_s;
    logic [3:0]        tile_s;

    // State and address registers; reset overrides everything, including a sweep in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_LOAD;
            addr_r  <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            addr_r  <= addr_next_s;
        end
    end

    // Sweep sequencing: count through the board, then park at address 0.
    always_comb begin
        state_next_s = state_r;
        addr_next_s  = addr_r;
        case (state_r)
            ST_LOAD: begin
                if (addr_r == LAST_ADDR) begin
                    state_next_s = ST_DONE;
                    addr_next_s  = {ADDR_W{1'b0}};
                end else begin
                    state_next_s = ST_LOAD;
                    addr_next_s  = addr_r + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                addr_next_s = {ADDR_W{1'b0}};
`ifdef RESET_BOARD_REPLAY_EN
                if (restart) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_DONE;
                end
`else
                state_next_s = ST_DONE;
`endif
            end
            default: begin
                state_next_s = ST_LOAD;
                addr_next_s  = {ADDR_W{1'b0}};
            end
        endcase
    end

    board_layout_rom #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_layout (
        .addr (addr_r),
        .tile (tile_s)
    );

    assign hold           = (state_r == ST_LOAD);
    assign overwrite_addr = addr_r;
    assign initial_data   = DATA_W'(tile_s);

endmodule

// File: tb/tb_reset_board_seq.sv
// Randomized self-checking bench for reset_board_seq against a sweep-position
// model and an arithmetic layout reference.
module tb_reset_board_seq;

    localparam int COLS  = 32;
    localparam int ROWS  = 32;
    localparam int CELLS = COLS * ROWS;

    logic       clk;
    logic       reset;
    logic       restart;
    logic       hold;
    logic [9:0] overwrite_addr;
    logic [3:0] initial_data;

    int n_cmp;
    int n_err;
    int m_pos;
    bit m_done;

    int spot_addr [8] = '{0, 33, 35, 66, 463, 494, 450, 944};
    int spot_val  [8] = '{1, 3, 2, 1, 4, 6, 1, 5};

    reset_board_seq dut (
        .clk            (clk),
        .reset          (reset),
`ifdef RESET_BOARD_REPLAY_EN
        .restart        (restart),
`endif
        .hold           (hold),
        .overwrite_addr (overwrite_addr),
        .initial_data   (initial_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (model pos %0d done %0d)",
                     tag, got, exp, m_pos, m_done);
        end
    endtask

    function automatic int ref_tile(input int a);
        int r, c, cr, cc;
        r  = a / COLS;
        c  = a % COLS;
        cr = ROWS / 2;
        cc = COLS / 2;
        if (a >= CELLS) return 0;
        if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) return 1;
        if (r == cr - 2 && c >= cc - 1 && c <= cc) return 4;
        if (r == cr - 1 && c >= cc - 2 && c <= cc + 1) return 6;
        if (r >= cr - 2 && r <= cr && c >= cc - 3 && c <= cc + 2) return 1;
        if (r == ROWS - 3 && c == cc) return 5;
        if ((r == 1 || r == ROWS - 2) && (c == 1 || c == COLS - 2)) return 3;
        if (r % 2 == 0 && c % 2 == 0) return 1;
        return 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_pos  = 0;
            m_done = 1'b0;
        end else if (!m_done) begin
            if (m_pos == CELLS - 1) begin
                m_done = 1'b1;
                m_pos  = 0;
            end else begin
                m_pos++;
            end
        end
`ifdef RESET_BOARD_REPLAY_EN
        else if (restart) begin
            m_done = 1'b0;
            m_pos  = 0;
        end
`endif
        #1;
        check_eq("hold", int'(hold), m_done ? 0 : 1);
        check_eq("addr", int'(overwrite_addr), m_pos);
        check_eq("data", int'(initial_data), ref_tile(m_pos));
        for (int i = 0; i < 8; i++) begin
            if (!m_done && m_pos == spot_addr[i])
                check_eq("spot", int'(initial_data), spot_val[i]);
        end
    endtask

    initial begin
        int guard;
        n_cmp   = 0;
        n_err   = 0;
        m_pos   = 0;
        m_done  = 1'b0;
        reset   = 1'b1;
        restart = 1'b0;

        // single-cycle reset, full sweep, then 20 parked cycles
        tick();
        reset = 1'b0;
        repeat (CELLS + 20) tick();

        // reset landing mid-sweep at address 500
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        guard = 0;
        while (m_pos != 500 && guard < 2000) begin
            tick();
            guard++;
        end
        check_eq("reach500", m_pos, 500);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (CELLS + 5) tick();

        // reset held for five cycles
        reset = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        repeat (4) tick();

`ifdef RESET_BOARD_REPLAY_EN
        repeat (CELLS + 10) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        guard = 0;
        while (m_pos != 300 && guard < 2000) begin
            tick();
            guard++;
        end
        restart = 1'b1;
        tick();
        check_eq("ign_restart", int'(overwrite_addr), 301);
        restart = 1'b0;
        repeat (CELLS) tick();
`endif

        // random resets (and restarts when replay is built in)
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 5)) tick();
                reset = 1'b0;
            end
`ifdef RESET_BOARD_REPLAY_EN
            restart = ($urandom_range(0, 99) == 0);
`endif
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reset_board_seq.md
Name: reset_board_seq

Overview:
- Board-initialisation sequencer for the PacMan playfield.
- After reset, it walks every tile address of the board RAM once, supplying the initial tile code for each address and raising `hold` for the whole sweep.
- Sits between the global reset and the board RAM write port.
- Game logic stays frozen while `hold` = 1.

Parameters:
- COLS, 32, board columns.
- ROWS, 32, board rows; COLS*ROWS must be ≤ 2^ADDR_W.
- ADDR_W, 10, tile address width.
- DATA_W, 4, tile code width.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- hold  output  1  load in progress; also the board RAM write enable.
- overwrite_addr  output  ADDR_W  tile address being written; address = row*COLS + col.
- initial_data  output  DATA_W  initial tile code for overwrite_addr.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- States: LOAD, DONE.
- Reset, taking priority over everything including mid-sweep: state ← LOAD, address counter ← 0. Outputs in the cycle after the reset edge: hold = 1, overwrite_addr = 0.
- LOAD, each clock edge: if addr == COLS*ROWS−1, then state ← DONE and addr ← 0; otherwise addr ← addr+1.
- DONE: stays in DONE until reset; addr is held at 0.
- hold = (state == LOAD), registered-state decode, no combinational path from reset.
- Timing: after the reset edge, hold remains 1 through 1024 more edges (default size). It drops after address 1023 has been presented for one cycle.
- initial_data is a purely combinational function of overwrite_addr (zero latency), valid in every state.
- Tile codes: EMPTY = 0, WALL = 1, PELLET = 2, POWER = 3, GATE = 4, PACMAN_SPAWN = 5, GHOST_SPAWN = 6. Codes 7–15 are unused.
- Layout. Let r = addr/COLS, c = addr%COLS, cr = ROWS/2, cc = COLS/2. The first matching rule wins:
  1. addr ≥ COLS*ROWS → EMPTY.
  2. r = 0, r = ROWS−1, c = 0 or c = COLS−1 → WALL.
  3. r = cr−2 and cc−1 ≤ c ≤ cc → GATE.
  4. r = cr−1 and cc−2 ≤ c ≤ cc+1 → GHOST_SPAWN.
  5. cr−2 ≤ r ≤ cr and cc−3 ≤ c ≤ cc+2 → WALL (ghost box).
  6. r = ROWS−3 and c = cc → PACMAN_SPAWN.
  7. (r, c) ∈ {(1,1), (1,COLS−2), (ROWS−2,1), (ROWS−2,COLS−2)} → POWER.
  8. r even and c even → WALL (pillars).
  9. Otherwise → PELLET.
- Division and modulo must be implemented with shifts and masks when COLS is a power of two.

Optional Feature:
- Macro: RESET_BOARD_REPLAY_EN.
- When defined: adds input port `restart` (1 bit). While in DONE, restart = 1 at a clock edge forces state ← LOAD and addr ← 0, replaying the sweep (used for level clear).
- restart is ignored while in LOAD.
- reset keeps priority over restart.
- When undefined: no port; DONE is left only via reset.

Decomposition:
- Package board_pkg: tile-code enum tile_t (DATA_W bits), plus COLS, ROWS, ADDR_W and DATA_W constants shared with the board RAM and the renderer.
- One sub-module, board_layout_rom: combinational addr → tile_t implementing the layout rules.
- reset_board_seq holds the FSM and counter.

Test Plan:
- Reset 1 cycle, then run → hold = 1 with overwrite_addr 0,1,2,…,1023 on consecutive cycles. hold = 0 from the next cycle with overwrite_addr = 0, staying there for 20 further cycles.
- Data spot checks during the sweep:
  - addr 0 → 1
  - addr 33 → 3
  - addr 35 → 2
  - addr 66 → 1
- Ghost and spawn spot checks:
  - addr 463 → 4
  - addr 494 → 6
  - addr 450 → 1
  - addr 944 → 5
- Reset asserted when overwrite_addr = 500 → next cycle addr = 0, hold = 1; the full 1024-cycle sweep then restarts.
- Reset held for 5 cycles → hold = 1 and overwrite_addr = 0 throughout; counting starts on the first edge with reset = 0.
- With RESET_BOARD_REPLAY_EN: restart pulsed in DONE → sweep from 0 repeats. Restart pulsed at addr 300 in LOAD → no effect; addr 301 follows.
